ctrl_param_bank: RTL and testbench

Parametrised, double-buffered successor to the dscope per-channel/per-slot parameter store.
Host commands write a shadow bank. A COMMIT command arms a copy of shadow to active, and the copy fires only at the next frame boundary, so pulser/ADC/DAC timing never sees a half-updated parameter set.
Adds registered per-slot output selection, host readback with valid/ready, and an error counter.

---
 rtl/ctrl_param_bank_pkg.sv | 146 ++++++++++++++
 rtl/ctrl_param_bank_if.sv | 20 ++
 rtl/ctrl_param_bank_decode.sv | 67 ++++++
 rtl/ctrl_param_bank.sv | 194 +++++++++++++++++++
 tb/tb_ctrl_param_bank.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_param_bank_pkg.sv
// Shared types, command encoding and reset defaults for the double-buffered
// per-channel/per-slot parameter bank.
package ctrl_param_pkg;

  // Command word layout
  localparam int CMD_CH_LSB   = 27;
  localparam int CMD_CH_W     = 4;
  localparam int CMD_SLOT_LSB = 24;
  localparam int CMD_SLOT_W   = 3;
  localparam int CMD_NCMD_LSB = 20;
  localparam int CMD_NCMD_W   = 4;
  localparam int CMD_DATA_LSB = 0;
  localparam int CMD_DATA_W   = 16;

  typedef enum logic [3:0] {
    NCMD_NOP      = 4'd0,
    NCMD_MASK     = 4'd1,
    NCMD_VCHN     = 4'd2,
    NCMD_HIT      = 4'd3,
    NCMD_GND      = 4'd4,
    NCMD_HUSH     = 4'd5,
    NCMD_COUNT    = 4'd6,
    NCMD_DAC      = 4'd7,
    NCMD_RATIO    = 4'd8,
    NCMD_TICK     = 4'd9,
    NCMD_TS_TIME  = 4'd10,
    NCMD_SYNC_DIV = 4'd11,
    NCMD_SYNC_CFG = 4'd12,
    NCMD_WHEEL    = 4'd13,
    NCMD_COMMIT   = 4'd14,
    NCMD_READBACK = 4'd15
  } ncmd_e;

  typedef struct packed {
    logic [3:0]  mask;
    logic [1:0]  vchn;
    logic [7:0]  hit;
    logic [7:0]  gnd;
    logic [3:0]  count;
    logic [15:0] hush;
    logic [7:0]  tick;
    logic [7:0]  ratio;
    logic [7:0]  dac;
  } param_entry_t;

  typedef struct packed {
    logic [15:0] in_sync_div;
    logic        sync_enabled;
    logic        int_ext_sync;
    logic [7:0]  wheel_add;
    logic [7:0]  frame_dec;
  } param_glob_t;

  localparam logic [7:0] DEF_HIT    = 8'd40;
  localparam logic [7:0] DEF_GND    = 8'd40;
  localparam logic [3:0] DEF_COUNT  = 4'd4;
  localparam logic [7:0] DEF_TICK   = 8'd64;
  localparam logic [7:0] DEF_RATIO  = 8'd12;
  localparam logic [7:0] DEF_DAC    = 8'd120;
  localparam logic [7:0] LAST_HIT   = 8'd20;
  localparam logic [7:0] LAST_GND   = 8'd60;
  localparam logic [3:0] LAST_COUNT = 4'd1;

  localparam param_glob_t GLOB_RESET = '{
    in_sync_div:  16'd100,
    sync_enabled: 1'b1,
    int_ext_sync: 1'b1,
    wheel_add:    8'd9,
    frame_dec:    8'd234
  };

  // The last channel gets its own pulse shape at power-up.
  function automatic param_entry_t reset_entry(int ch, int n_ch, logic [15:0] hush);
    param_entry_t e;
    e.mask  = 4'(1 << (ch % 4));
    e.vchn  = 2'(ch % 4);
    e.hit   = DEF_HIT;
    e.gnd   = DEF_GND;
    e.count = DEF_COUNT;
    e.hush  = hush;
    e.tick  = DEF_TICK;
    e.ratio = DEF_RATIO;
    e.dac   = DEF_DAC;
    if (ch == n_ch - 1) begin
      e.hit   = LAST_HIT;
      e.gnd   = LAST_GND;
      e.count = LAST_COUNT;
    end
    return e;
  endfunction

  function automatic param_entry_t apply_field(param_entry_t e, ncmd_e f, logic [15:0] d);
    param_entry_t r;
    r = e;
    case (f)
      NCMD_MASK:  r.mask  = d[3:0];
      NCMD_VCHN:  r.vchn  = d[1:0];
      NCMD_HIT:   r.hit   = d[7:0];
      NCMD_GND:   r.gnd   = d[7:0];
      NCMD_HUSH:  r.hush  = d;
      NCMD_COUNT: r.count = d[3:0];
      NCMD_DAC:   r.dac   = d[7:0];
      NCMD_RATIO: r.ratio = d[7:0];
      NCMD_TICK:  r.tick  = d[7:0];
      default:    ;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] entry_field(param_entry_t e, ncmd_e f);
    logic [15:0] v;
    v = '0;
    case (f)
      NCMD_MASK:  v = {12'd0, e.mask};
      NCMD_VCHN:  v = {14'd0, e.vchn};
      NCMD_HIT:   v = {8'd0, e.hit};
      NCMD_GND:   v = {8'd0, e.gnd};
      NCMD_HUSH:  v = e.hush;
      NCMD_COUNT: v = {12'd0, e.count};
      NCMD_DAC:   v = {8'd0, e.dac};
      NCMD_RATIO: v = {8'd0, e.ratio};
      NCMD_TICK:  v = {8'd0, e.tick};
      default:    v = '0;
    endcase
    return v;
  endfunction

  function automatic param_glob_t apply_glob(param_glob_t g, ncmd_e f, logic [15:0] d);
    param_glob_t r;
    r = g;
    case (f)
      NCMD_SYNC_DIV: r.in_sync_div = d;
      NCMD_SYNC_CFG: begin
        r.sync_enabled = d[1];
        r.int_ext_sync = d[0];
      end
      NCMD_WHEEL: begin
        r.wheel_add = d[15:8];
        r.frame_dec = d[7:0];
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_param_bank_if.sv
// Host-side command and readback bus of the parameter bank.
interface ctrl_param_bank_if;
  logic [31:0] i_cmd_magic;
  logic [31:0] i_cmd_command;
  logic        i_cmd_vld;
  logic        o_cmd_rdy;
  logic [15:0] o_rb_data;
  logic        o_rb_vld;
  logic        i_rb_rdy;

  modport master (
    output i_cmd_magic, i_cmd_command, i_cmd_vld, i_rb_rdy,
    input  o_cmd_rdy, o_rb_data, o_rb_vld
  );

  modport slave (
    input  i_cmd_magic, i_cmd_command, i_cmd_vld, i_rb_rdy,
    output o_cmd_rdy, o_rb_data, o_rb_vld
  );
endinterface

// File: rtl/ctrl_param_bank_decode.sv
// Combinational command decoder: classifies an accepted command into a
// write/commit/readback strobe or an error, and extracts index and data.
module param_cmd_decode
  import ctrl_param_pkg::*;
#(
  parameter int          N_CH   = 4,
  parameter int          N_SLOT = 4,
  parameter logic [31:0] MAGIC  = 32'hF0AA550F,
  parameter int          IW     = 4,
  parameter int          SW     = 2
) (
  input  logic [31:0]   cmd_magic,
  input  logic [31:0]   cmd_command,
  input  logic          accept,
  output logic          entry_we,
  output logic          ts_we,
  output logic          glob_we,
  output logic          commit_req,
  output logic          rb_req,
  output logic          err_inc,
  output ncmd_e         ncmd,
  output logic [IW-1:0] ent_idx,
  output logic [SW-1:0] slot_idx,
  output logic [15:0]   data
);

  logic [CMD_CH_W-1:0]   ch;
  logic [CMD_SLOT_W-1:0] slot;
  logic                  bad;
  logic                  unused_bits;

  assign ch          = cmd_command[CMD_CH_LSB +: CMD_CH_W];
  assign slot        = cmd_command[CMD_SLOT_LSB +: CMD_SLOT_W];
  assign ncmd        = ncmd_e'(cmd_command[CMD_NCMD_LSB +: CMD_NCMD_W]);
  assign data        = cmd_command[CMD_DATA_LSB +: CMD_DATA_W];
  assign ent_idx     = IW'(int'(ch) * N_SLOT + int'(slot));
  assign slot_idx    = SW'(slot);
  assign unused_bits = ^{cmd_command[31], cmd_command[19:16]};

  // NOTE: every output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    entry_we   = 1'b0;
    ts_we      = 1'b0;
    glob_we    = 1'b0;
    commit_req = 1'b0;
    rb_req     = 1'b0;
    err_inc    = 1'b0;
    bad = (cmd_magic != MAGIC) || (ncmd == NCMD_NOP) ||
          (int'(ch) >= N_CH) || (int'(slot) >= N_SLOT);
    if (accept) begin
      if (bad) begin
        err_inc = 1'b1;
      end else begin
        case (ncmd)
          NCMD_MASK, NCMD_VCHN, NCMD_HIT, NCMD_GND, NCMD_HUSH,
          NCMD_COUNT, NCMD_DAC, NCMD_RATIO, NCMD_TICK: entry_we = 1'b1;
          NCMD_TS_TIME:                                ts_we = 1'b1;
          NCMD_SYNC_DIV, NCMD_SYNC_CFG, NCMD_WHEEL:    glob_we = 1'b1;
          NCMD_COMMIT:                                 commit_req = 1'b1;
          NCMD_READBACK:                               rb_req = 1'b1;
          default:                                     ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ctrl_param_bank.sv
// Double-buffered parameter bank: host writes a shadow copy, COMMIT arms a
// whole-bank transfer to active that fires on the next frame boundary.
module ctrl_param_bank
  import ctrl_param_pkg::*;
#(
  parameter int          N_CH          = 4,
  parameter int          N_SLOT        = 4,
  parameter logic [31:0] MAGIC         = 32'hF0AA550F,
  parameter logic [15:0] DEF_HUSH      = 16'd1000,
  parameter logic [15:0] DEF_SLOT_TIME = 16'd3600
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ctrl_param_bank_if.slave       bus,
  input  logic                   i_frame_start,
  input  logic [2:0]             i_slot,
  output logic [16*N_SLOT-1:0]   o_ts_time,
  output logic [4*N_CH-1:0]      o_pulse_mask,
  output logic [8*N_CH-1:0]      o_pulse_hit,
  output logic [8*N_CH-1:0]      o_pulse_gnd,
  output logic [8*N_CH-1:0]      o_adc_tick,
  output logic [8*N_CH-1:0]      o_adc_ratio,
  output logic [8*N_CH-1:0]      o_dac_level,
  output logic [4*N_CH-1:0]      o_pulse_count,
  output logic [16*N_CH-1:0]     o_pulse_hush,
  output logic [2*N_CH-1:0]      o_adc_vchn,
  output logic [15:0]            o_in_sync_div,
  output logic                   o_sync_enabled,
  output logic                   o_int_ext_sync,
  output logic [7:0]             o_wheel_add,
  output logic [7:0]             o_frame_dec,
  output logic                   o_commit_pend,
  output logic                   o_commit_done,
  output logic [7:0]             o_err_cnt
);

  localparam int N_ENT = N_CH * N_SLOT;
  localparam int IW    = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam int SW    = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;

  param_entry_t sh_ent  [N_ENT];
  param_entry_t act_ent [N_ENT];
  logic [15:0]  sh_ts   [N_SLOT];
  logic [15:0]  act_ts  [N_SLOT];
  param_glob_t  sh_glob;
  param_glob_t  act_glob;
  param_entry_t out_ent [N_CH];

  logic          commit_pend;
  logic          commit_done;
  logic          copy_fire;
  logic          rb_vld;
  logic [15:0]   rb_data;
  logic [15:0]   rb_next;
  ncmd_e         rb_field;
  logic [7:0]    err_cnt;
  logic          cmd_rdy;
  logic          accept;

  logic          entry_we;
  logic          ts_we;
  logic          glob_we;
  logic          commit_req;
  logic          rb_req;
  logic          err_inc;
  ncmd_e         ncmd;
  logic [IW-1:0] ent_idx;
  logic [SW-1:0] slot_idx;
  logic [15:0]   dec_data;

  assign cmd_rdy   = ~(rb_vld && ~bus.i_rb_rdy);
  assign accept    = bus.i_cmd_vld && cmd_rdy;
  // commit_pend is the registered value, so a COMMIT in the strobe cycle waits a frame
  assign copy_fire = i_frame_start && commit_pend;

  param_cmd_decode #(
    .N_CH   (N_CH),
    .N_SLOT (N_SLOT),
    .MAGIC  (MAGIC),
    .IW     (IW),
    .SW     (SW)
  ) u_decode (
    .cmd_magic   (bus.i_cmd_magic),
    .cmd_command (bus.i_cmd_command),
    .accept      (accept),
    .entry_we    (entry_we),
    .ts_we       (ts_we),
    .glob_we     (glob_we),
    .commit_req  (commit_req),
    .rb_req      (rb_req),
    .err_inc     (err_inc),
    .ncmd        (ncmd),
    .ent_idx     (ent_idx),
    .slot_idx    (slot_idx),
    .data        (dec_data)
  );

  // NOTE: both banks carry per-entry power-up values, so they are plain flops reset in a loop, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        sh_ent[i]  <= reset_entry(i / N_SLOT, N_CH, DEF_HUSH);
        act_ent[i] <= reset_entry(i / N_SLOT, N_CH, DEF_HUSH);
      end
      for (int s = 0; s < N_SLOT; s++) begin
        sh_ts[s]  <= DEF_SLOT_TIME;
        act_ts[s] <= DEF_SLOT_TIME;
      end
      sh_glob  <= GLOB_RESET;
      act_glob <= GLOB_RESET;
    end else begin
      // NOTE: non-blocking updates mean a same-cycle shadow write lands after the copy samples shadow.
      if (copy_fire) begin
        act_ent  <= sh_ent;
        act_ts   <= sh_ts;
        act_glob <= sh_glob;
      end
      if (entry_we) sh_ent[ent_idx] <= apply_field(sh_ent[ent_idx], ncmd, dec_data);
      if (ts_we)    sh_ts[slot_idx] <= dec_data;
      if (glob_we)  sh_glob         <= apply_glob(sh_glob, ncmd, dec_data);
    end
  end

  always_comb begin
    rb_field = ncmd_e'(dec_data[3:0]);
    rb_next  = '0;
    case (rb_field)
      NCMD_TS_TIME:  rb_next = act_ts[slot_idx];
      NCMD_SYNC_DIV: rb_next = act_glob.in_sync_div;
      NCMD_SYNC_CFG: rb_next = {14'd0, act_glob.sync_enabled, act_glob.int_ext_sync};
      NCMD_WHEEL:    rb_next = {act_glob.wheel_add, act_glob.frame_dec};
      default:       rb_next = entry_field(act_ent[ent_idx], rb_field);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pend <= 1'b0;
      commit_done <= 1'b0;
      rb_vld      <= 1'b0;
      rb_data     <= '0;
      err_cnt     <= '0;
    end else begin
      commit_done <= copy_fire;
      if (commit_req)     commit_pend <= 1'b1;
      else if (copy_fire) commit_pend <= 1'b0;
      if (rb_req) begin
        rb_vld  <= 1'b1;
        rb_data <= rb_next;
      end else if (bus.i_rb_rdy) begin
        rb_vld  <= 1'b0;
      end
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Out-of-range slot index freezes the per-channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) out_ent[c] <= reset_entry(c, N_CH, DEF_HUSH);
    end else if (int'(i_slot) < N_SLOT) begin
      for (int c = 0; c < N_CH; c++) out_ent[c] <= act_ent[IW'(c * N_SLOT + int'(i_slot))];
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign o_pulse_mask[4*c +: 4]   = out_ent[c].mask;
    assign o_adc_vchn[2*c +: 2]     = out_ent[c].vchn;
    assign o_pulse_hit[8*c +: 8]    = out_ent[c].hit;
    assign o_pulse_gnd[8*c +: 8]    = out_ent[c].gnd;
    assign o_pulse_count[4*c +: 4]  = out_ent[c].count;
    assign o_pulse_hush[16*c +: 16] = out_ent[c].hush;
    assign o_adc_tick[8*c +: 8]     = out_ent[c].tick;
    assign o_adc_ratio[8*c +: 8]    = out_ent[c].ratio;
    assign o_dac_level[8*c +: 8]    = out_ent[c].dac;
  end

  for (genvar s = 0; s < N_SLOT; s++) begin : g_ts
    assign o_ts_time[16*s +: 16] = act_ts[s];
  end

  assign o_in_sync_div  = act_glob.in_sync_div;
  assign o_sync_enabled = act_glob.sync_enabled;
  assign o_int_ext_sync = act_glob.int_ext_sync;
  assign o_wheel_add    = act_glob.wheel_add;
  assign o_frame_dec    = act_glob.frame_dec;
  assign o_commit_pend  = commit_pend;
  assign o_commit_done  = commit_done;
  assign o_err_cnt      = err_cnt;
  assign bus.o_cmd_rdy  = cmd_rdy;
  assign bus.o_rb_vld   = rb_vld;
  assign bus.o_rb_data  = rb_data;

endmodule

// File: tb/tb_ctrl_param_bank.sv
// Directed bench for ctrl_param_bank; readback responses are scored against
// a queue of expected values pushed when each READBACK is issued.
module tb_ctrl_param_bank;
  import ctrl_param_pkg::*;

  localparam int          N_CH   = 4;
  localparam int          N_SLOT = 4;
  localparam logic [31:0] MAGIC  = 32'hF0AA550F;
  localparam logic [31:0] BAD_MAGIC = 32'h12345678;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_param_bank_if bus ();

  logic                 i_frame_start;
  logic [2:0]           i_slot;
  logic [16*N_SLOT-1:0] o_ts_time;
  logic [4*N_CH-1:0]    o_pulse_mask;
  logic [8*N_CH-1:0]    o_pulse_hit;
  logic [8*N_CH-1:0]    o_pulse_gnd;
  logic [8*N_CH-1:0]    o_adc_tick;
  logic [8*N_CH-1:0]    o_adc_ratio;
  logic [8*N_CH-1:0]    o_dac_level;
  logic [4*N_CH-1:0]    o_pulse_count;
  logic [16*N_CH-1:0]   o_pulse_hush;
  logic [2*N_CH-1:0]    o_adc_vchn;
  logic [15:0]          o_in_sync_div;
  logic                 o_sync_enabled;
  logic                 o_int_ext_sync;
  logic [7:0]           o_wheel_add;
  logic [7:0]           o_frame_dec;
  logic                 o_commit_pend;
  logic                 o_commit_done;
  logic [7:0]           o_err_cnt;

  ctrl_param_bank #(
    .N_CH          (N_CH),
    .N_SLOT        (N_SLOT),
    .MAGIC         (MAGIC),
    .DEF_HUSH      (16'd1000),
    .DEF_SLOT_TIME (16'd3600)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .i_frame_start  (i_frame_start),
    .i_slot         (i_slot),
    .o_ts_time      (o_ts_time),
    .o_pulse_mask   (o_pulse_mask),
    .o_pulse_hit    (o_pulse_hit),
    .o_pulse_gnd    (o_pulse_gnd),
    .o_adc_tick     (o_adc_tick),
    .o_adc_ratio    (o_adc_ratio),
    .o_dac_level    (o_dac_level),
    .o_pulse_count  (o_pulse_count),
    .o_pulse_hush   (o_pulse_hush),
    .o_adc_vchn     (o_adc_vchn),
    .o_in_sync_div  (o_in_sync_div),
    .o_sync_enabled (o_sync_enabled),
    .o_int_ext_sync (o_int_ext_sync),
    .o_wheel_add    (o_wheel_add),
    .o_frame_dec    (o_frame_dec),
    .o_commit_pend  (o_commit_pend),
    .o_commit_done  (o_commit_done),
    .o_err_cnt      (o_err_cnt)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] rb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dac(int c);
    return 32'(o_dac_level[8*c +: 8]);
  endfunction
  function automatic logic [31:0] ts(int s);
    return 32'(o_ts_time[16*s +: 16]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] ncmd, input logic [3:0] ch, input logic [2:0] slot,
                          input logic [15:0] data, input logic [31:0] magic = MAGIC);
    bus.i_cmd_magic   = magic;
    bus.i_cmd_command = {1'b0, ch, slot, ncmd, 4'h0, data};
    bus.i_cmd_vld     = 1'b1;
    tick();
    bus.i_cmd_vld     = 1'b0;
  endtask

  task automatic strobe();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  task automatic readback(input logic [3:0] field, input logic [3:0] ch, input logic [2:0] slot,
                          input logic [15:0] exp);
    rb_q.push_back(exp);
    send_cmd(NCMD_READBACK, ch, slot, {12'd0, field});
    check("rb_vld", 32'(bus.o_rb_vld), 1);
    tick();
  endtask

  task automatic bad_cmd(input int i);
    case (i % 3)
      0:       send_cmd(NCMD_DAC, 4'd0, 3'd0, 16'h00AA, BAD_MAGIC);
      1:       send_cmd(NCMD_DAC, 4'(N_CH), 3'd0, 16'h00AA);
      default: send_cmd(NCMD_DAC, 4'd0, 3'd5, 16'h00AA);
    endcase
  endtask

  // Scoreboard side: every accepted readback response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_rb_vld && bus.i_rb_rdy) begin
      check("rb_expected", 32'(rb_q.size() != 0), 1);
      if (rb_q.size() != 0) check("rb_data", 32'(bus.o_rb_data), 32'(rb_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_cmd_magic   = MAGIC;
    bus.i_cmd_command = '0;
    bus.i_cmd_vld     = 1'b0;
    bus.i_rb_rdy      = 1'b1;
    i_frame_start     = 1'b0;
    i_slot            = 3'd0;
    rst_n             = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset defaults
    for (int c = 0; c < N_CH; c++) check("rst_dac", dac(c), 120);
    for (int s = 0; s < N_SLOT; s++) check("rst_ts", ts(s), 3600);
    check("rst_hit_last",   32'(o_pulse_hit[8*(N_CH-1) +: 8]), 20);
    check("rst_gnd_last",   32'(o_pulse_gnd[8*(N_CH-1) +: 8]), 60);
    check("rst_count_last", 32'(o_pulse_count[4*(N_CH-1) +: 4]), 1);
    check("rst_hit_ch0",    32'(o_pulse_hit[7:0]), 40);
    check("rst_mask_ch1",   32'(o_pulse_mask[7:4]), 2);
    check("rst_vchn_ch3",   32'(o_adc_vchn[7:6]), 3);
    check("rst_hush_ch2",   32'(o_pulse_hush[47:32]), 1000);
    check("rst_sync_div",   32'(o_in_sync_div), 100);
    check("rst_sync_en",    32'(o_sync_enabled), 1);
    check("rst_wheel",      32'(o_wheel_add), 9);
    check("rst_frame",      32'(o_frame_dec), 234);
    check("rst_pend",       32'(o_commit_pend), 0);
    check("rst_rb_vld",     32'(bus.o_rb_vld), 0);
    check("rst_cmd_rdy",    32'(bus.o_cmd_rdy), 1);
    check("rst_err",        32'(o_err_cnt), 0);

    // Shadow write is invisible until COMMIT plus a strobe
    i_slot = 3'd2;
    send_cmd(NCMD_DAC, 4'd1, 3'd2, 16'h0055);
    for (int k = 0; k < 3; k++) begin
      strobe();
      check("nocommit_done", 32'(o_commit_done), 0);
      tick();
      check("nocommit_dac", dac(1), 120);
    end
    readback(NCMD_DAC, 4'd1, 3'd2, 16'd120);
    send_cmd(NCMD_COMMIT, 4'd0, 3'd0, 16'h0000);
    check("commit_pend", 32'(o_commit_pend), 1);
    strobe();
    check("commit_done", 32'(o_commit_done), 1);
    check("commit_clear", 32'(o_commit_pend), 0);
    check("commit_lat0", dac(1), 120);
    tick();
    check("commit_done_pulse", 32'(o_commit_done), 0);
    check("commit_lat1", dac(1), 32'h55);
    readback(NCMD_DAC, 4'd1, 3'd2, 16'h0055);

    // Field truncation
    send_cmd(NCMD_HIT, 4'd2, 3'd1, 16'h01FF);
    send_cmd(NCMD_COUNT, 4'd2, 3'd1, 16'hFFFF);
    send_cmd(NCMD_COMMIT, 4'd0, 3'd0, 16'h0000);
    strobe();
    readback(NCMD_HIT, 4'd2, 3'd1, 16'h00FF);
    readback(NCMD_COUNT, 4'd2, 3'd1, 16'h000F);

    // COMMIT in the strobe cycle waits for the following strobe
    send_cmd(NCMD_TS_TIME, 4'd0, 3'd1, 16'd500);
    i_frame_start = 1'b1;
    send_cmd(NCMD_COMMIT, 4'd0, 3'd0, 16'h0000);
    i_frame_start = 1'b0;
    check("same_cyc_done", 32'(o_commit_done), 0);
    check("same_cyc_pend", 32'(o_commit_pend), 1);
    check("same_cyc_ts", ts(1), 3600);
    tick();
    tick();
    check("same_cyc_pend_hold", 32'(o_commit_pend), 1);
    strobe();
    check("late_done", 32'(o_commit_done), 1);
    check("late_pend", 32'(o_commit_pend), 0);
    check("late_ts", ts(1), 500);
    readback(NCMD_TS_TIME, 4'd0, 3'd1, 16'd500);

    // Shadow write in the copy cycle: active keeps the pre-write value
    i_slot = 3'd0;
    send_cmd(NCMD_COMMIT, 4'd0, 3'd0, 16'h0000);
    i_frame_start = 1'b1;
    send_cmd(NCMD_DAC, 4'd0, 3'd0, 16'h0077);
    i_frame_start = 1'b0;
    check("wr_copy_done", 32'(o_commit_done), 1);
    tick();
    check("wr_copy_old", dac(0), 120);
    send_cmd(NCMD_COMMIT, 4'd0, 3'd0, 16'h0000);
    strobe();
    tick();
    check("wr_copy_new", dac(0), 32'h77);

    // Stalled readback blocks the command bus
    bus.i_rb_rdy = 1'b0;
    rb_q.push_back(16'd1000);
    send_cmd(NCMD_READBACK, 4'd0, 3'd0, {12'd0, 4'(NCMD_HUSH)});
    bus.i_cmd_magic   = MAGIC;
    bus.i_cmd_command = {1'b0, 4'd0, 3'd0, 4'(NCMD_COMMIT), 4'h0, 16'h0000};
    bus.i_cmd_vld     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("stall_vld",  32'(bus.o_rb_vld), 1);
      check("stall_data", 32'(bus.o_rb_data), 1000);
      check("stall_rdy",  32'(bus.o_cmd_rdy), 0);
      check("stall_pend", 32'(o_commit_pend), 0);
      tick();
    end
    bus.i_rb_rdy = 1'b1;
    #1;
    check("unstall_rdy", 32'(bus.o_cmd_rdy), 1);
    tick();
    bus.i_cmd_vld = 1'b0;
    check("queued_accept", 32'(o_commit_pend), 1);
    check("unstall_vld", 32'(bus.o_rb_vld), 0);
    strobe();
    tick();

    // Out-of-range slot holds per-channel outputs
    i_slot = 3'd2;
    tick();
    tick();
    check("slot2_dac", dac(1), 32'h55);
    i_slot = 3'd7;
    tick();
    tick();
    check("slot_hold_dac", dac(1), 32'h55);
    i_slot = 3'd0;
    tick();
    tick();
    check("slot0_dac", dac(1), 120);

    // Globals
    send_cmd(NCMD_WHEEL, 4'd0, 3'd0, 16'h1234);
    send_cmd(NCMD_SYNC_CFG, 4'd0, 3'd0, 16'h0002);
    send_cmd(NCMD_SYNC_DIV, 4'd0, 3'd0, 16'd777);
    send_cmd(NCMD_COMMIT, 4'd0, 3'd0, 16'h0000);
    strobe();
    check("glob_wheel",   32'(o_wheel_add), 32'h12);
    check("glob_frame",   32'(o_frame_dec), 32'h34);
    check("glob_sync_en", 32'(o_sync_enabled), 1);
    check("glob_int_ext", 32'(o_int_ext_sync), 0);
    check("glob_div",     32'(o_in_sync_div), 777);
    readback(NCMD_WHEEL, 4'd0, 3'd0, 16'h1234);

    // Error handling and saturation
    send_cmd(NCMD_DAC, 4'd0, 3'd0, 16'h0011, BAD_MAGIC);
    send_cmd(NCMD_DAC, 4'(N_CH), 3'd0, 16'h0022);
    send_cmd(NCMD_NOP, 4'd0, 3'd0, 16'h0033);
    check("err_three", 32'(o_err_cnt), 3);
    send_cmd(NCMD_COMMIT, 4'd0, 3'd0, 16'h0000);
    strobe();
    readback(NCMD_DAC, 4'd0, 3'd0, 16'h0077);
    readback(NCMD_DAC, 4'd1, 3'd0, 16'd120);
    for (int i = 0; i < 251; i++) bad_cmd(i);
    check("err_254", 32'(o_err_cnt), 254);
    bad_cmd(0);
    check("err_255", 32'(o_err_cnt), 255);
    for (int i = 0; i < 48; i++) bad_cmd(i);
    check("err_sat", 32'(o_err_cnt), 255);

    // Reset mid-operation with commit armed and a readback stalled
    send_cmd(NCMD_DAC, 4'd3, 3'd0, 16'h0099);
    send_cmd(NCMD_COMMIT, 4'd0, 3'd0, 16'h0000);
    check("pre_rst_pend", 32'(o_commit_pend), 1);
    bus.i_rb_rdy = 1'b0;
    send_cmd(NCMD_READBACK, 4'd0, 3'd0, {12'd0, 4'(NCMD_DAC)});
    check("pre_rst_rb_vld", 32'(bus.o_rb_vld), 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_pend",   32'(o_commit_pend), 0);
    check("arst_rb_vld", 32'(bus.o_rb_vld), 0);
    check("arst_err",    32'(o_err_cnt), 0);
    check("arst_ts",     ts(1), 3600);
    check("arst_wheel",  32'(o_wheel_add), 9);
    check("arst_dac0",   dac(0), 120);
    repeat (2) @(posedge clk);
    bus.i_rb_rdy = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_dac3", dac(3), 120);
    check("post_rst_int_ext", 32'(o_int_ext_sync), 1);
    strobe();
    check("post_rst_done", 32'(o_commit_done), 0);
    tick();
    check("post_rst_dac3_b", dac(3), 120);
    readback(NCMD_DAC, 4'd3, 3'd0, 16'd120);

    // Drain scoreboard (bounded)
    for (int k = 0; k < 10 && rb_q.size() != 0; k++) tick();
    check("rb_queue_empty", 32'(rb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
